move_scheduler: RTL
===================

Name: move_scheduler

Overview:
- Sequences all piece-movement requests into the playfield/colour datapath, in the CLK25M domain.
- Requesters: three raw buttons (left, right, soft-drop) and an internal gravity timer.
- Conditions the buttons, arbitrates the four requesters at fixed priority, and issues one command at a time over a valid/ready handshake.
- Issues commands only during vertical blanking, so the playfield never changes mid-scan.

Parameters:
- DEBOUNCE_CYCLES, 250000, CLK25M cycles a button level must stay stable before it is accepted (10 ms).
- GRAVITY_FRAMES, 30, frames between gravity ticks.
- CMDS_PER_FRAME, 2, maximum commands issued per blanking interval.
- REPEAT_DELAY_FRAMES, 12, held-button frames before the first auto-repeat (AUTO_REPEAT_EN only).
- REPEAT_RATE_FRAMES, 4, frames between later auto-repeats (AUTO_REPEAT_EN only).

Ports:
- CLK25M  in  1  25 MHz pixel clock
- Reset_N  in  1  asynchronous reset, active-low
- buttonL  in  1  raw left button, asynchronous
- buttonR  in  1  raw right button, asynchronous
- buttonD  in  1  raw soft-drop button, asynchronous
- VBlank  in  1  high during vertical blanking, from VGA timing
- FrameStart  in  1  one-cycle pulse at the start of each frame
- Pause  in  1  freezes gravity and blocks new issues
- CmdValid  out  1  command valid
- CmdOp  out  2  00 left, 01 right, 10 soft-drop, 11 gravity
- CmdReady  in  1  datapath accepts the command
- Busy  out  1  high when any request is pending or a command is in flight
- debugLED  out  1  toggles on each completed handshake

Behaviour:
- Reset (async assert, sync release): CmdValid=0, CmdOp=00, Busy=0, debugLED=0. All pending flags, counters and stable button levels are 0. FSM is in IDLE.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce counter clears whenever the synchronized level equals the stable level; otherwise it increments.
  - At DEBOUNCE_CYCLES-1 the stable level takes the synchronized value and the counter clears.
  - A 0->1 edge of the stable level sets pend[btn].
- Gravity:
  - Frame counter increments on FrameStart when Pause=0.
  - At GRAVITY_FRAMES-1 it wraps to 0 and sets pendG.
  - Issuing a soft-drop clears the frame counter (resync).
- Pending flags are sticky. A second request while a flag is already set is merged; there is no queue depth. If a flag is set and cleared in the same cycle, set wins.
- Arbitration priority: D > G > L > R.
- Issue budget: frame issue counter clears on FrameStart and saturates at CMDS_PER_FRAME.
- FSM:
  - IDLE -> ISSUE when VBlank=1, Pause=0, any flag is pending, and the issue count is below CMDS_PER_FRAME. The winner's flag is cleared.
  - ISSUE: CmdValid=1 and CmdOp=winner from the next cycle. CmdOp is held stable until handshake. On CmdValid&CmdReady: increment the issue count, toggle debugLED, go to GAP.
  - GAP: CmdValid=0 for exactly one cycle, then IDLE.
- Latency: a pending flag set during VBlank produces CmdValid 1 cycle later.
- Handshake, once started, completes even if VBlank falls or Pause rises. CmdValid is never withdrawn.
- Pause: freezes the gravity counter, keeps pending flags, and blocks IDLE->ISSUE.
- If FrameStart coincides with a handshake, the issue count clears and the handshake is not counted toward the new frame.
- Busy = (any pend) | (state != IDLE).

Optional Feature:
- Macro: MOVE_SCHED_AUTO_REPEAT_EN.
- Defined: while stable L or R stays high, a per-button frame counter sets pend[btn] after REPEAT_DELAY_FRAMES frames, then every REPEAT_RATE_FRAMES frames. The counter resets on release. Soft-drop does not repeat.
- Undefined: only press edges set pend. The repeat counters and the repeat parameters have no effect.

Decomposition:
- Package tetris_pkg:
  - CmdOp encodings CMD_LEFT, CMD_RIGHT, CMD_DROP, CMD_GRAV.
  - FSM state encodings IDLE, ISSUE, GAP.
- Sub-module btn_conditioner (synchronizer + debounce + rising-edge pulse), instantiated three times. The arbiter, FSM and gravity logic stay in move_scheduler.

Test Plan:
- Bench parameters for every scenario: DEBOUNCE_CYCLES=4, GRAVITY_FRAMES=3, CMDS_PER_FRAME=2, CmdReady=1.
- Debounce: buttonL glitches high for 2 cycles -> no command. buttonL held 6 cycles, then VBlank=1 -> exactly one CmdOp=00, debugLED toggles.
- Gravity: 3 FrameStart pulses with VBlank=1 -> one CmdOp=11 after the third pulse. With Pause=1, 6 pulses -> no CmdValid.
- Priority and budget: L, R and D pending, VBlank=1 -> CmdOp sequence 10, 00 in this frame. After the next FrameStart -> 01.
- Handshake hold: CmdReady=0 for 5 cycles while VBlank falls -> CmdValid=1 and CmdOp unchanged throughout. CmdReady=1 -> handshake completes, then GAP cycle with CmdValid=0.
- Reset mid-issue: Reset_N=0 while CmdValid=1 -> CmdValid=0 and Busy=0 immediately, with no clock edge required.
- Auto-repeat (MOVE_SCHED_AUTO_REPEAT_EN defined, REPEAT_DELAY_FRAMES=12, REPEAT_RATE_FRAMES=4): buttonR held for 20 frames -> CmdOp=01 issued at frames 0, 12, 16 and 20.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared encodings for the move scheduler: command opcodes and FSM states.
package tetris_pkg;

    typedef enum logic [1:0] {
        CMD_LEFT  = 2'b00,
        CMD_RIGHT = 2'b01,
        CMD_DROP  = 2'b10,
        CMD_GRAV  = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        GAP   = 2'b10
    } sched_state_t;

endpackage

// File: rtl/btn_conditioner.sv
// Raw button conditioning: 2-flop synchronizer, level debounce and a one-cycle
// pulse on each accepted 0->1 transition of the stable level.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync_meta;
    logic          sync_lvl;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_lvl  <= 1'b0;
            cnt       <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_lvl  <= sync_meta;
            rise      <= 1'b0;
            if (sync_lvl == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_lvl;
                rise  <= sync_lvl;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates left/right/soft-drop buttons and gravity, issuing one command per
// valid/ready handshake during VBlank. Define MOVE_SCHED_AUTO_REPEAT_EN to enable held-button auto-repeat.
//
// state | meaning
// IDLE  | waiting for VBlank, a pending request and issue budget
// ISSUE | CmdValid high, CmdOp held until CmdReady
// GAP   | one cycle with CmdValid low after each handshake
module move_scheduler
    import tetris_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = 250000,
    parameter int unsigned GRAVITY_FRAMES      = 30,
    parameter int unsigned CMDS_PER_FRAME      = 2,
    parameter int unsigned REPEAT_DELAY_FRAMES = 12,
    parameter int unsigned REPEAT_RATE_FRAMES  = 4
) (
    input  logic       CLK25M,
    input  logic       Reset_N,
    input  logic       buttonL,
    input  logic       buttonR,
    input  logic       buttonD,
    input  logic       VBlank,
    input  logic       FrameStart,
    input  logic       Pause,
    output logic       CmdValid,
    output logic [1:0] CmdOp,
    input  logic       CmdReady,
    output logic       Busy,
    output logic       debugLED
);
    localparam int FW = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;
    localparam int IW = $clog2(CMDS_PER_FRAME + 1);

    logic [1:0]   rst_pipe;
    logic         rst_n;
    logic         level_l, level_r, level_d;
    logic         rise_l, rise_r, rise_d;
    logic [1:0]   rep_fire;
    logic         pend_l, pend_r, pend_d, pend_g;
    logic [FW-1:0] frame_cnt;
    logic [IW-1:0] issue_cnt;
    sched_state_t state;
    cmd_op_t      op_q;
    cmd_op_t      winner;
    logic         any_pend, start, handshake, grav_tick, drop_issue;

    // Async assert, synchronous release of the internal reset.
    always_ff @(posedge CLK25M or negedge Reset_N) begin
        if (!Reset_N) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (
        .clk(CLK25M), .rst_n(rst_n), .raw(buttonL), .level(level_l), .rise(rise_l));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
        .clk(CLK25M), .rst_n(rst_n), .raw(buttonR), .level(level_r), .rise(rise_r));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_d (
        .clk(CLK25M), .rst_n(rst_n), .raw(buttonD), .level(level_d), .rise(rise_d));

`ifdef MOVE_SCHED_AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                                   REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
    localparam int RW = $clog2(RMAX + 1);

    logic [1:0]    held;
    logic [1:0]    rep_run;
    logic [RW-1:0] rep_cnt [2];
    logic          unused_sig;

    assign held       = {level_r, level_l};
    assign unused_sig = level_d;

    // rep_run marks that the first delayed repeat has fired; later ones use the rate.
    always_ff @(posedge CLK25M or negedge rst_n) begin
        if (!rst_n) begin
            rep_run  <= 2'b00;
            rep_fire <= 2'b00;
            rep_cnt  <= '{default: '0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                rep_fire[i] <= 1'b0;
                if (!held[i]) begin
                    rep_run[i] <= 1'b0;
                    rep_cnt[i] <= '0;
                end else if (FrameStart) begin
                    if ((!rep_run[i] && rep_cnt[i] == RW'(REPEAT_DELAY_FRAMES - 1)) ||
                        (rep_run[i] && rep_cnt[i] == RW'(REPEAT_RATE_FRAMES - 1))) begin
                        rep_fire[i] <= 1'b1;
                        rep_run[i]  <= 1'b1;
                        rep_cnt[i]  <= '0;
                    end else begin
                        rep_cnt[i] <= rep_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    logic unused_sig;

    assign rep_fire   = 2'b00;
    assign unused_sig = level_d ^ level_l ^ level_r ^
                        (REPEAT_DELAY_FRAMES != 0) ^ (REPEAT_RATE_FRAMES != 0);
`endif

    always_comb begin
        winner = CMD_RIGHT;
        if (pend_d)      winner = CMD_DROP;
        else if (pend_g) winner = CMD_GRAV;
        else if (pend_l) winner = CMD_LEFT;
    end

    assign any_pend   = pend_l | pend_r | pend_d | pend_g;
    assign start      = (state == IDLE) && VBlank && !Pause && any_pend &&
                        (issue_cnt < IW'(CMDS_PER_FRAME));
    assign handshake  = (state == ISSUE) && CmdReady;
    assign grav_tick  = FrameStart && !Pause && (frame_cnt == FW'(GRAVITY_FRAMES - 1));
    assign drop_issue = start && (winner == CMD_DROP);

    // Sticky request flags: a set in the same cycle as the clear wins.
    always_ff @(posedge CLK25M or negedge rst_n) begin
        if (!rst_n) begin
            pend_l    <= 1'b0;
            pend_r    <= 1'b0;
            pend_d    <= 1'b0;
            pend_g    <= 1'b0;
            frame_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            pend_l <= (pend_l & ~(start && winner == CMD_LEFT))  | rise_l | rep_fire[0];
            pend_r <= (pend_r & ~(start && winner == CMD_RIGHT)) | rise_r | rep_fire[1];
            pend_d <= (pend_d & ~drop_issue) | rise_d;
            pend_g <= (pend_g & ~(start && winner == CMD_GRAV)) | grav_tick;

            if (drop_issue)                  frame_cnt <= '0;
            else if (grav_tick)              frame_cnt <= '0;
            else if (FrameStart && !Pause)   frame_cnt <= frame_cnt + 1'b1;

            if (FrameStart)
                issue_cnt <= '0;
            else if (handshake && issue_cnt < IW'(CMDS_PER_FRAME))
                issue_cnt <= issue_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK25M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            CmdValid <= 1'b0;
            op_q     <= CMD_LEFT;
            debugLED <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= ISSUE;
                    CmdValid <= 1'b1;
                    op_q     <= winner;
                end
                ISSUE: if (CmdReady) begin
                    state    <= GAP;
                    CmdValid <= 1'b0;
                    debugLED <= ~debugLED;
                end
                GAP: state <= IDLE;
                default: begin
                    state    <= IDLE;
                    CmdValid <= 1'b0;
                end
            endcase
        end
    end

    assign CmdOp = op_q;
    assign Busy  = any_pend | (state != IDLE);

endmodule
